// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer.
package trap_pkg;

    // Sequencer states: trap entry walks T_*, MRET walks M_*, both end in REDIRECT.
    typedef enum logic [3:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STATUS,
        T_TVEC,
        M_STATUS,
        M_EPC,
        REDIRECT
    } trap_state_e;

    // Machine-mode CSR addresses touched by the sequencer.
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // mstatus field positions.
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Privilege encodings.
    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

endpackage

// File: rtl/trap_vec_calc.sv
// Trap vector target from mtvec: vectored mode only applies to interrupts,
// every other mode/cause combination jumps to the aligned base.
module trap_vec_calc
    import trap_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic [3:0]            cause,
    input  logic                  is_irq,
    output logic [DATA_WIDTH-1:0] target
);

    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] offset;

    // Base is mtvec with the mode bits cleared; offset is cause*4, sum wraps.
    always_comb begin
        base   = {mtvec[DATA_WIDTH-1:2], 2'b00};
        offset = DATA_WIDTH'({cause, 2'b00});
        target = base;
        if (mtvec[1:0] == 2'b01 && is_irq) begin
            target = base + offset;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: saves trap state through the CSR port, performs the mstatus
// read-modify-writes, fetches the new PC, issues one redirect and owns privilege.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CSR_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  irq_trap_i,
    input  logic [3:0]            irq_cause_i,
    input  logic                  irq_en_i,
    input  logic                  exc_valid_i,
    input  logic [3:0]            exc_cause_i,
    input  logic [DATA_WIDTH-1:0] exc_tval_i,
    input  logic                  mret_i,
    input  logic [DATA_WIDTH-1:0] commit_pc_i,
    input  logic [CSR_WIDTH-1:0]  pipe_csr_addr_i,
    input  logic [DATA_WIDTH-1:0] pipe_csr_wdata_i,
    input  logic                  pipe_csr_we_i,
    input  logic                  pipe_csr_re_i,
    output logic [DATA_WIDTH-1:0] pipe_csr_rdata_o,
    output logic [CSR_WIDTH-1:0]  csr_addr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  csr_we_o,
    output logic                  csr_re_o,
    input  logic [DATA_WIDTH-1:0] csr_rdata_i,
    output logic                  stall_o,
    output logic                  redirect_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic [1:0]            priv_o
);

    trap_state_e           state_reg;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [3:0]            cause_reg;
    logic [DATA_WIDTH-1:0] tval_reg;
    logic                  is_irq_reg;
    logic [1:0]            new_priv_reg;
    logic [DATA_WIDTH-1:0] target_reg;
    logic [1:0]            priv_reg;
    logic                  redirect_reg;

    logic                  idle;
    logic                  take_exc;
    logic                  take_irq;
    logic                  take_mret;
    logic                  accept;
    logic [DATA_WIDTH-1:0] status_trap;
    logic [DATA_WIDTH-1:0] status_mret;
    logic [DATA_WIDTH-1:0] vec_target;

    // Acceptance priority: exception, then enabled interrupt, then MRET.
    always_comb begin
        idle      = (state_reg == IDLE);
        take_exc  = exc_valid_i;
        take_irq  = !exc_valid_i && irq_trap_i && irq_en_i;
        take_mret = !exc_valid_i && !(irq_trap_i && irq_en_i) && mret_i;
        accept    = idle && (take_exc || take_irq || take_mret);
    end

    // mstatus RMW values; every bit not named here is carried through unchanged.
    always_comb begin
        status_trap = csr_rdata_i;
        status_trap[MSTATUS_MPIE] = csr_rdata_i[MSTATUS_MIE];
        status_trap[MSTATUS_MIE]  = 1'b0;
        status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_reg;
        status_mret = csr_rdata_i;
        status_mret[MSTATUS_MIE]  = csr_rdata_i[MSTATUS_MPIE];
        status_mret[MSTATUS_MPIE] = 1'b1;
        status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    end

    trap_vec_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_vec_calc (
        .mtvec (csr_rdata_i),
        .cause (cause_reg),
        .is_irq(is_irq_reg),
        .target(vec_target)
    );

    // CSR port mux: pipeline passthrough when idle, sequencer accesses otherwise.
    always_comb begin
        csr_addr_o  = '0;
        csr_wdata_o = '0;
        csr_we_o    = 1'b0;
        csr_re_o    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!accept) begin
                    csr_addr_o  = pipe_csr_addr_i;
                    csr_wdata_o = pipe_csr_wdata_i;
                    csr_we_o    = pipe_csr_we_i;
                    csr_re_o    = pipe_csr_re_i;
                end
            end
            T_EPC: begin
                csr_addr_o  = CSR_WIDTH'(CSR_MEPC);
                csr_wdata_o = {pc_reg[DATA_WIDTH-1:2], 2'b00};
                csr_we_o    = 1'b1;
            end
            T_CAUSE: begin
                csr_addr_o  = CSR_WIDTH'(CSR_MCAUSE);
                csr_wdata_o = {is_irq_reg, {(DATA_WIDTH-5){1'b0}}, cause_reg};
                csr_we_o    = 1'b1;
            end
            T_TVAL: begin
                csr_addr_o  = CSR_WIDTH'(CSR_MTVAL);
                csr_wdata_o = tval_reg;
                csr_we_o    = 1'b1;
            end
            T_STATUS: begin
                csr_addr_o  = CSR_WIDTH'(CSR_MSTATUS);
                csr_wdata_o = status_trap;
                csr_we_o    = 1'b1;
                csr_re_o    = 1'b1;
            end
            T_TVEC: begin
                csr_addr_o = CSR_WIDTH'(CSR_MTVEC);
                csr_re_o   = 1'b1;
            end
            M_STATUS: begin
                csr_addr_o  = CSR_WIDTH'(CSR_MSTATUS);
                csr_wdata_o = status_mret;
                csr_we_o    = 1'b1;
                csr_re_o    = 1'b1;
            end
            M_EPC: begin
                csr_addr_o = CSR_WIDTH'(CSR_MEPC);
                csr_re_o   = 1'b1;
            end
            default: ;
        endcase
        // A reset landing mid-sequence must not leave a partial write behind.
        if (!rst_n) begin
            csr_we_o = 1'b0;
            csr_re_o = 1'b0;
        end
    end

    // Pipeline-facing status; stall covers the accept cycle combinationally.
    always_comb begin
        stall_o          = rst_n && (!idle || accept);
        pipe_csr_rdata_o = stall_o ? '0 : csr_rdata_i;
        redirect_o       = redirect_reg;
        redirect_pc_o    = target_reg;
        priv_o           = priv_reg;
    end

    // Sequencer FSM with trap latches, target capture and privilege update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pc_reg       <= '0;
            cause_reg    <= '0;
            tval_reg     <= '0;
            is_irq_reg   <= 1'b0;
            new_priv_reg <= PRIV_M;
            target_reg   <= '0;
            priv_reg     <= PRIV_M;
            redirect_reg <= 1'b0;
        end else begin
            redirect_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        pc_reg       <= commit_pc_i;
                        cause_reg    <= take_exc ? exc_cause_i : irq_cause_i;
                        tval_reg     <= take_exc ? exc_tval_i : '0;
                        is_irq_reg   <= take_irq;
                        new_priv_reg <= PRIV_M;
                        state_reg    <= take_mret ? M_STATUS : T_EPC;
                    end
                end
                T_EPC:    state_reg <= T_CAUSE;
                T_CAUSE:  state_reg <= T_TVAL;
                T_TVAL:   state_reg <= T_STATUS;
                T_STATUS: state_reg <= T_TVEC;
                T_TVEC: begin
                    target_reg   <= vec_target;
                    redirect_reg <= 1'b1;
                    state_reg    <= REDIRECT;
                end
                M_STATUS: begin
                    new_priv_reg <= csr_rdata_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                    state_reg    <= M_EPC;
                end
                M_EPC: begin
                    target_reg   <= {csr_rdata_i[DATA_WIDTH-1:2], 2'b00};
                    redirect_reg <= 1'b1;
                    state_reg    <= REDIRECT;
                end
                REDIRECT: begin
                    priv_reg  <= new_priv_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
